// File: rtl/dns_ip_tx.sv
// dns_ip_tx: DNS reply transmit stage.
// Accepts one flattened DNS message with its address/port tuple. It emits a
// UDP header with source and destination swapped, then streams the payload
// one byte per beat on an AXI-stream.
// Optional build macro DNS_IP_TX_STATUS_EN adds a saturating drop counter
// and a busy flag.
module dns_ip_tx #(
  parameter int MAX_BYTES     = 512,
  parameter int UDP_HDR_BYTES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_dns_valid,
  output logic          s_dns_ready,
  input  logic [31:0]   s_udp_src_ip,
  input  logic [31:0]   s_udp_dst_ip,
  input  logic [15:0]   s_udp_src_port,
  input  logic [15:0]   s_udp_dst_port,
  input  logic [15:0]   s_dns_length,
  input  logic [4095:0] s_dns_pkt,
  output logic          m_udp_hdr_valid,
  input  logic          m_udp_hdr_ready,
  output logic [15:0]   m_udp_source_port,
  output logic [15:0]   m_udp_dest_port,
  output logic [31:0]   m_udp_source_ip,
  output logic [31:0]   m_udp_dest_ip,
  output logic [15:0]   m_udp_length,
  output logic [7:0]    m_udp_payload_axis_tdata,
  output logic          m_udp_payload_axis_tvalid,
  input  logic          m_udp_payload_axis_tready,
  output logic          m_udp_payload_axis_tlast,
  output logic          m_udp_payload_axis_tuser
`ifdef DNS_IP_TX_STATUS_EN
  ,
  output logic [15:0]   status_drop_count,
  output logic          status_busy
`endif
);

  typedef enum logic [1:0] {IDLE, DROP, HDR, PAYLOAD} state_t;

  state_t        state, state_d;
  logic [4095:0] pkt_q, pkt_d;
  logic [15:0]   len_q, len_d;
  logic [9:0]    idx_q, idx_d;

  logic          ready_d;
  logic          hdr_valid_d;
  logic [15:0]   src_port_d, dst_port_d, udp_len_d;
  logic [31:0]   src_ip_d, dst_ip_d;
  logic [7:0]    tdata_d;
  logic          tvalid_d, tlast_d;

  logic [9:0]    sel_idx;
  logic [11:0]   sel_lsb;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_idx_w;

  assign m_udp_payload_axis_tuser = 1'b0;

  // Byte lookup for the beat that will be presented next: byte 0 right after
  // the header handshake, otherwise the byte following the current one.
  always_comb begin
    sel_idx   = (state == PAYLOAD) ? idx_q + 10'd1 : '0;
    sel_lsb   = 12'(13'd4088 - {sel_idx, 3'b000});
    sel_byte  = pkt_q[sel_lsb +: 8];
    sel_idx_w = {6'b0, sel_idx};
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    pkt_d       = pkt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ready_d     = 1'b0;
    hdr_valid_d = m_udp_hdr_valid;
    src_port_d  = m_udp_source_port;
    dst_port_d  = m_udp_dest_port;
    src_ip_d    = m_udp_source_ip;
    dst_ip_d    = m_udp_dest_ip;
    udp_len_d   = m_udp_length;
    tdata_d     = m_udp_payload_axis_tdata;
    tvalid_d    = m_udp_payload_axis_tvalid;
    tlast_d     = m_udp_payload_axis_tlast;

    case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (s_dns_valid && s_dns_ready) begin
          ready_d = 1'b0;
          pkt_d   = s_dns_pkt;
          len_d   = s_dns_length;
          idx_d   = '0;
          if (s_dns_length == 16'd0 || s_dns_length > 16'(MAX_BYTES)) begin
            state_d = DROP;
          end else begin
            state_d     = HDR;
            hdr_valid_d = 1'b1;
            src_port_d  = s_udp_dst_port;
            dst_port_d  = s_udp_src_port;
            src_ip_d    = s_udp_dst_ip;
            dst_ip_d    = s_udp_src_ip;
            udp_len_d   = s_dns_length + 16'(UDP_HDR_BYTES);
          end
        end
      end
      DROP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      HDR: begin
        if (m_udp_hdr_ready) begin
          hdr_valid_d = 1'b0;
          state_d     = PAYLOAD;
          idx_d       = '0;
          tvalid_d    = 1'b1;
          tdata_d     = sel_byte;
          tlast_d     = (len_q == 16'd1);
        end
      end
      PAYLOAD: begin
        if (m_udp_payload_axis_tready) begin
          if (m_udp_payload_axis_tlast) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = IDLE;
            ready_d  = 1'b1;
          end else begin
            idx_d   = sel_idx;
            tdata_d = sel_byte;
            tlast_d = (sel_idx_w == len_q - 16'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      pkt_q                     <= '0;
      len_q                     <= '0;
      idx_q                     <= '0;
      s_dns_ready               <= 1'b0;
      m_udp_hdr_valid           <= 1'b0;
      m_udp_source_port         <= '0;
      m_udp_dest_port           <= '0;
      m_udp_source_ip           <= '0;
      m_udp_dest_ip             <= '0;
      m_udp_length              <= '0;
      m_udp_payload_axis_tdata  <= '0;
      m_udp_payload_axis_tvalid <= 1'b0;
      m_udp_payload_axis_tlast  <= 1'b0;
    end else begin
      state                     <= state_d;
      pkt_q                     <= pkt_d;
      len_q                     <= len_d;
      idx_q                     <= idx_d;
      s_dns_ready               <= ready_d;
      m_udp_hdr_valid           <= hdr_valid_d;
      m_udp_source_port         <= src_port_d;
      m_udp_dest_port           <= dst_port_d;
      m_udp_source_ip           <= src_ip_d;
      m_udp_dest_ip             <= dst_ip_d;
      m_udp_length              <= udp_len_d;
      m_udp_payload_axis_tdata  <= tdata_d;
      m_udp_payload_axis_tvalid <= tvalid_d;
      m_udp_payload_axis_tlast  <= tlast_d;
    end
  end

`ifdef DNS_IP_TX_STATUS_EN
  // Status: saturating count of dropped messages, busy mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_drop_count <= '0;
      status_busy       <= 1'b0;
    end else begin
      status_busy <= (state_d != IDLE);
      if (state != DROP && state_d == DROP && status_drop_count != 16'hFFFF)
        status_drop_count <= status_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dns_ip_tx.sv
// tb_dns_ip_tx: directed self-checking bench for dns_ip_tx.
module tb_dns_ip_tx;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_dns_valid;
  logic          s_dns_ready;
  logic [31:0]   s_udp_src_ip, s_udp_dst_ip;
  logic [15:0]   s_udp_src_port, s_udp_dst_port, s_dns_length;
  logic [4095:0] s_dns_pkt;
  logic          m_udp_hdr_valid, m_udp_hdr_ready;
  logic [15:0]   m_udp_source_port, m_udp_dest_port, m_udp_length;
  logic [31:0]   m_udp_source_ip, m_udp_dest_ip;
  logic [7:0]    tdata;
  logic          tvalid, tready, tlast, tuser;
`ifdef DNS_IP_TX_STATUS_EN
  logic [15:0]   status_drop_count;
  logic          status_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_bytes [512];

  always #5 clk = ~clk;

  dns_ip_tx #(.MAX_BYTES(512), .UDP_HDR_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .s_dns_valid(s_dns_valid), .s_dns_ready(s_dns_ready),
    .s_udp_src_ip(s_udp_src_ip), .s_udp_dst_ip(s_udp_dst_ip),
    .s_udp_src_port(s_udp_src_port), .s_udp_dst_port(s_udp_dst_port),
    .s_dns_length(s_dns_length), .s_dns_pkt(s_dns_pkt),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_source_ip(m_udp_source_ip), .m_udp_dest_ip(m_udp_dest_ip),
    .m_udp_length(m_udp_length),
    .m_udp_payload_axis_tdata(tdata), .m_udp_payload_axis_tvalid(tvalid),
    .m_udp_payload_axis_tready(tready), .m_udp_payload_axis_tlast(tlast),
    .m_udp_payload_axis_tuser(tuser)
`ifdef DNS_IP_TX_STATUS_EN
    , .status_drop_count(status_drop_count), .status_busy(status_busy)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bytes(input int seed);
    for (int k = 0; k < 512; k++) exp_bytes[k] = 8'((k * seed + 8'h5A) & 8'hFF);
  endtask

  task automatic build_pkt();
    logic [11:0] lsb;
    for (int k = 0; k < 512; k++) begin
      lsb = 12'(4088 - 8 * k);
      s_dns_pkt[lsb +: 8] = exp_bytes[k];
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!s_dns_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!s_dns_ready) check_eq("ready_wait", {63'd0, s_dns_ready}, 64'd1);
  endtask

  // Send one valid message using the current tuple inputs and exp_bytes,
  // then check header and payload. mode 0: tready always 1, mode 1: toggling.
  // reset_at >= 0 asserts rst while that beat is presented.
  task automatic run_msg(input int len, input int hdr_stall, input int mode,
                         input int reset_at, input bit hold_valid);
    logic [31:0] e_sip, e_dip;
    logic [15:0] e_sp, e_dp;
    int consumed, cyc;
    e_sip = s_udp_src_ip;   e_dip = s_udp_dst_ip;
    e_sp  = s_udp_src_port; e_dp  = s_udp_dst_port;
    build_pkt();
    s_dns_length = 16'(len);
    s_dns_valid  = 1'b1;
    wait_ready();
    tick();
    if (hold_valid) begin
      // A different message waits on the input while this one is busy.
      s_udp_src_ip = 32'h0000_0001; s_udp_dst_ip = 32'h0000_0002;
      s_udp_src_port = 16'd7;       s_udp_dst_port = 16'd9;
      s_dns_length = 16'd2;
      s_dns_pkt = '0;
      s_dns_pkt[4095:4080] = 16'h1122;
    end else begin
      s_dns_valid = 1'b0;
    end
    check_eq("hdr_valid", {63'd0, m_udp_hdr_valid}, 64'd1);
    check_eq("ready_busy", {63'd0, s_dns_ready}, 64'd0);
`ifdef DNS_IP_TX_STATUS_EN
    check_eq("busy", {63'd0, status_busy}, 64'd1);
`endif
    for (int i = 0; i <= hdr_stall; i++) begin
      check_eq("hdr_src_ip", {32'd0, m_udp_source_ip}, {32'd0, e_dip});
      check_eq("hdr_dst_ip", {32'd0, m_udp_dest_ip}, {32'd0, e_sip});
      check_eq("hdr_src_port", {48'd0, m_udp_source_port}, {48'd0, e_dp});
      check_eq("hdr_dst_port", {48'd0, m_udp_dest_port}, {48'd0, e_sp});
      check_eq("hdr_len", {48'd0, m_udp_length}, 64'(16'(len + 8)));
      check_eq("hdr_hold_valid", {63'd0, m_udp_hdr_valid}, 64'd1);
      check_eq("no_tvalid_hdr", {63'd0, tvalid}, 64'd0);
      if (i < hdr_stall) begin
        m_udp_hdr_ready = 1'b0;
        tick();
      end
    end
    m_udp_hdr_ready = 1'b1;
    tick();
    m_udp_hdr_ready = 1'b0;
    check_eq("hdr_done", {63'd0, m_udp_hdr_valid}, 64'd0);
    consumed = 0;
    cyc = 0;
    while (consumed < len && cyc < 2000) begin
      check_eq("tvalid", {63'd0, tvalid}, 64'd1);
      check_eq("tdata", {56'd0, tdata}, {56'd0, exp_bytes[consumed]});
      check_eq("tlast", {63'd0, tlast}, {63'd0, consumed == len - 1});
      check_eq("ready_pl", {63'd0, s_dns_ready}, 64'd0);
      if (consumed == reset_at) begin
        rst = 1'b1;
        tick();
        check_eq("rst_tvalid", {63'd0, tvalid}, 64'd0);
        check_eq("rst_tlast", {63'd0, tlast}, 64'd0);
        check_eq("rst_hdr", {63'd0, m_udp_hdr_valid}, 64'd0);
        check_eq("rst_ready", {63'd0, s_dns_ready}, 64'd0);
        rst = 1'b0;
        tready = 1'b0;
        tick();
        check_eq("rst_ready_back", {63'd0, s_dns_ready}, 64'd1);
        check_eq("rst_no_tvalid", {63'd0, tvalid}, 64'd0);
        return;
      end
      tready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      tick();
      if (tready) consumed++;
      cyc++;
    end
    if (consumed < len) check_eq("payload_timeout", 64'(consumed), 64'(len));
    check_eq("end_tvalid", {63'd0, tvalid}, 64'd0);
    check_eq("end_tlast", {63'd0, tlast}, 64'd0);
    check_eq("end_ready", {63'd0, s_dns_ready}, 64'd1);
    tready = 1'b0;
  endtask

  task automatic run_drop(input int len);
    s_dns_length = 16'(len);
    s_dns_valid  = 1'b1;
    wait_ready();
    tick();
    s_dns_valid = 1'b0;
    check_eq("drop_ready0", {63'd0, s_dns_ready}, 64'd0);
    check_eq("drop_hdr0", {63'd0, m_udp_hdr_valid}, 64'd0);
    check_eq("drop_tv0", {63'd0, tvalid}, 64'd0);
    tick();
    check_eq("drop_ready1", {63'd0, s_dns_ready}, 64'd1);
    check_eq("drop_hdr1", {63'd0, m_udp_hdr_valid}, 64'd0);
    check_eq("drop_tv1", {63'd0, tvalid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_dns_valid = 1'b0;
    s_udp_src_ip = '0; s_udp_dst_ip = '0;
    s_udp_src_port = '0; s_udp_dst_port = '0;
    s_dns_length = '0; s_dns_pkt = '0;
    m_udp_hdr_ready = 1'b0;
    tready = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", {63'd0, s_dns_ready}, 64'd0);
    check_eq("rst_hdr_valid", {63'd0, m_udp_hdr_valid}, 64'd0);
    check_eq("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check_eq("rst_tlast", {63'd0, tlast}, 64'd0);
    check_eq("rst_tuser", {63'd0, tuser}, 64'd0);
    check_eq("rst_fields", {m_udp_source_ip, m_udp_dest_ip}, 64'd0);
    check_eq("rst_ports", {16'd0, m_udp_source_port, m_udp_dest_port, m_udp_length}, 64'd0);
`ifdef DNS_IP_TX_STATUS_EN
    check_eq("rst_drops", {48'd0, status_drop_count}, 64'd0);
    check_eq("rst_busy", {63'd0, status_busy}, 64'd0);
`endif
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", {63'd0, s_dns_ready}, 64'd1);

    // Basic 4-byte reply with swapped tuple.
    fill_bytes(3);
    exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD;
    exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;
    s_udp_src_ip = 32'h0A00_0001; s_udp_src_port = 16'd1234;
    s_udp_dst_ip = 32'h0A00_0002; s_udp_dst_port = 16'd53;
    run_msg(4, 0, 0, -1, 1'b0);
`ifdef DNS_IP_TX_STATUS_EN
    check_eq("idle_busy", {63'd0, status_busy}, 64'd0);
`endif

    // Single-byte and full-size messages.
    fill_bytes(5);
    s_udp_src_ip = 32'hC0A8_0101; s_udp_src_port = 16'hFFFF;
    s_udp_dst_ip = 32'h0808_0808; s_udp_dst_port = 16'd53;
    run_msg(1, 0, 0, -1, 1'b0);
    fill_bytes(7);
    run_msg(512, 0, 0, -1, 1'b0);

    // Header back-pressure, then stalling payload.
    fill_bytes(11);
    s_udp_src_ip = 32'h1234_5678; s_udp_src_port = 16'd4000;
    s_udp_dst_ip = 32'h8765_4321; s_udp_dst_port = 16'd5353;
    run_msg(6, 5, 1, -1, 1'b0);

    // Invalid lengths are dropped.
    run_drop(0);
    run_drop(600);
`ifdef DNS_IP_TX_STATUS_EN
    check_eq("drop_count", {48'd0, status_drop_count}, 64'd2);
`endif

    // Reset on the third payload beat, then an intact 4-byte message.
    fill_bytes(13);
    run_msg(10, 0, 0, 2, 1'b0);
    check_eq("rst_fields_clr", {48'd0, m_udp_length}, 64'd0);
    fill_bytes(17);
    run_msg(4, 0, 0, -1, 1'b0);

    // Input held valid with different data while busy is ignored; it is
    // accepted only once the block is idle again.
    fill_bytes(19);
    s_udp_src_ip = 32'h0A00_0001; s_udp_src_port = 16'd1234;
    s_udp_dst_ip = 32'h0A00_0002; s_udp_dst_port = 16'd53;
    run_msg(5, 0, 0, -1, 1'b1);
    tick();
    s_dns_valid = 1'b0;
    check_eq("held_hdr_valid", {63'd0, m_udp_hdr_valid}, 64'd1);
    check_eq("held_len", {48'd0, m_udp_length}, 64'd10);
    check_eq("held_src_port", {48'd0, m_udp_source_port}, 64'd9);
    check_eq("held_dst_ip", {32'd0, m_udp_dest_ip}, 64'd1);
    m_udp_hdr_ready = 1'b1;
    tick();
    m_udp_hdr_ready = 1'b0;
    check_eq("held_b0", {55'd0, tvalid, tdata}, {55'd0, 1'b1, 8'h11});
    check_eq("held_b0_last", {63'd0, tlast}, 64'd0);
    tready = 1'b1;
    tick();
    check_eq("held_b1", {55'd0, tvalid, tdata}, {55'd0, 1'b1, 8'h22});
    check_eq("held_b1_last", {63'd0, tlast}, 64'd1);
    tick();
    tready = 1'b0;
    check_eq("held_end", {62'd0, tvalid, s_dns_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
